// File: rtl/fpu_pkg.sv
// Shared FPU definitions: adder FSM states, rounding-bit positions and the
// canonical quiet-NaN builder.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND
    } fadd_state_t;

    localparam int G_POS = 2;
    localparam int R_POS = 1;
    localparam int S_POS = 0;

    // Returns sign=0, exponent all-ones, mantissa MSB set; caller slices to width.
    function automatic logic [127:0] qnan_bits(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; an all-zero input yields W.
module fpu_lzc #(
    parameter int W = 27
) (
    input  logic [W-1:0]               value,
    output logic [$clog2(W+1)-1:0]     count
);
    localparam int CW = $clog2(W + 1);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fadd_rne.sv
// Multi-cycle float adder/subtractor, round-to-nearest-even, 5-cycle latency.
// Optional special-value decoding is enabled by defining FADD_SPECIAL_EN.
module fadd_rne
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sub,
    input  logic [EXP_W+MAN_W:0]     adata,
    input  logic [EXP_W+MAN_W:0]     bdata,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     ovf,
    output logic                     unf,
    output logic                     nx,
    output logic                     done,
    output logic                     busy
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int FW = MAN_W + 4;
    localparam int XW = EXP_W + 2;
    localparam int LW = $clog2(FW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    fadd_state_t state_reg, state_next;

    logic [W-1:0]  a_reg, b_reg;
    logic          sub_reg;
    logic [FW-1:0] big_sig_reg, small_sig_reg, norm_reg;
    logic [FW:0]   sum_reg;
    logic [XW-1:0] exp_reg;
    logic          sign_reg, eff_sub_reg, zero_reg;
    logic          spec_reg;
    logic [W-1:0]  spec_val_reg;
    logic [W-1:0]  result_reg;
    logic          ovf_reg, unf_reg, nx_reg, done_reg;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ALIGN: order by magnitude, flush exp==0 operands, shift smaller with G/R/S
    logic             a_sign, b_sign, a_ge_b, big_sign;
    logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp;
    logic [MAN_W-1:0] a_man, b_man, big_man, small_man;
    logic [FW-1:0]    big_sig_next, small_full, small_shift, small_sig_next;
    logic [XW-1:0]    exp_diff;
    logic             lost;
    logic             spec_next;
    logic [W-1:0]     spec_val_next;

    always_comb begin
        a_sign    = a_reg[W-1];
        b_sign    = b_reg[W-1] ^ sub_reg;
        a_exp     = a_reg[W-2:MAN_W];
        b_exp     = b_reg[W-2:MAN_W];
        a_man     = a_reg[MAN_W-1:0];
        b_man     = b_reg[MAN_W-1:0];
        a_ge_b    = a_reg[W-2:0] >= b_reg[W-2:0];
        big_sign  = a_ge_b ? a_sign : b_sign;
        big_exp   = a_ge_b ? a_exp : b_exp;
        big_man   = a_ge_b ? a_man : b_man;
        small_exp = a_ge_b ? b_exp : a_exp;
        small_man = a_ge_b ? b_man : a_man;
        big_sig_next = (big_exp == '0) ? '0 : {1'b1, big_man, 3'b000};
        small_full   = (small_exp == '0) ? '0 : {1'b1, small_man, 3'b000};
        exp_diff     = {2'b00, big_exp} - {2'b00, small_exp};
        small_shift  = small_full >> exp_diff;
        lost         = |(small_full & ~({FW{1'b1}} << exp_diff));
        if (exp_diff >= XW'(MAN_W + 3)) begin
            small_sig_next = {{(FW-1){1'b0}}, |small_full};
        end else begin
            small_sig_next = {small_shift[FW-1:1], small_shift[0] | lost};
        end
    end

`ifdef FADD_SPECIAL_EN
    localparam logic [127:0] QNAN_WIDE = qnan_bits(EXP_W, MAN_W);
    logic a_inf, b_inf, a_nan, b_nan;
    always_comb begin
        a_inf = (a_exp == EXP_ONES) && (a_man == '0);
        b_inf = (b_exp == EXP_ONES) && (b_man == '0);
        a_nan = (a_exp == EXP_ONES) && (a_man != '0);
        b_nan = (b_exp == EXP_ONES) && (b_man != '0);
        spec_next = a_inf | b_inf | a_nan | b_nan;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
            spec_val_next = QNAN_WIDE[W-1:0];
        else if (a_inf)
            spec_val_next = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        else
            spec_val_next = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
    end
`else
    assign spec_next     = 1'b0;
    assign spec_val_next = '0;
`endif

    // NORM: carry renormalises right, otherwise shift out leading zeros
    logic [LW-1:0] lz;
    logic [FW-1:0] norm_next;
    logic [XW-1:0] exp_norm_next;

    fpu_lzc #(.W(FW)) u_lzc (
        .value (sum_reg[FW-1:0]),
        .count (lz)
    );

    always_comb begin
        if (sum_reg[FW]) begin
            norm_next     = {sum_reg[FW:2], sum_reg[1] | sum_reg[0]};
            exp_norm_next = exp_reg + XW'(1);
        end else begin
            norm_next     = sum_reg[FW-1:0] << lz;
            exp_norm_next = exp_reg - XW'(lz);
        end
    end

    // ROUND: nearest-even increment, then range check on the final exponent
    logic             g_bit, r_bit, s_bit, lsb, inc, inexact;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] man_r;
    logic [XW-1:0]    exp_r;
    logic [W-1:0]     result_next;
    logic             ovf_next, unf_next, nx_next;

    always_comb begin
        g_bit   = norm_reg[G_POS];
        r_bit   = norm_reg[R_POS];
        s_bit   = norm_reg[S_POS];
        lsb     = norm_reg[3];
        inc     = g_bit & (r_bit | s_bit | lsb);
        inexact = g_bit | r_bit | s_bit;
        rnd     = {1'b0, norm_reg[FW-1:3]} + (MAN_W+2)'(inc);
        exp_r   = exp_reg + XW'(rnd[MAN_W+1]);
        man_r   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        result_next = '0;
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        nx_next     = 1'b0;
        if (spec_reg) begin
            result_next = spec_val_reg;
        end else if (zero_reg) begin
            result_next = '0;
        end else if (!exp_r[XW-1] && exp_r >= {2'b00, EXP_ONES}) begin
            result_next = {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
            ovf_next    = 1'b1;
            nx_next     = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            result_next = {sign_reg, {(W-1){1'b0}}};
            unf_next    = 1'b1;
            nx_next     = 1'b1;
        end else begin
            result_next = {sign_reg, exp_r[EXP_W-1:0], man_r};
            nx_next     = inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            nx_reg     <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (en) begin
                    a_reg   <= adata;
                    b_reg   <= bdata;
                    sub_reg <= sub;
                end
                ALIGN: begin
                    big_sig_reg   <= big_sig_next;
                    small_sig_reg <= small_sig_next;
                    sign_reg      <= big_sign;
                    eff_sub_reg   <= a_sign ^ b_sign;
                    exp_reg       <= {2'b00, big_exp};
                    spec_reg      <= spec_next;
                    spec_val_reg  <= spec_val_next;
                end
                ADD: begin
                    sum_reg <= eff_sub_reg ? ({1'b0, big_sig_reg} - {1'b0, small_sig_reg})
                                           : ({1'b0, big_sig_reg} + {1'b0, small_sig_reg});
                end
                NORM: begin
                    norm_reg <= norm_next;
                    exp_reg  <= exp_norm_next;
                    zero_reg <= (sum_reg == '0);
                end
                ROUND: begin
                    result_reg <= result_next;
                    ovf_reg    <= ovf_next;
                    unf_reg    <= unf_next;
                    nx_reg     <= nx_next;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign ovf    = ovf_reg;
    assign unf    = unf_reg;
    assign nx     = nx_reg;
    assign done   = done_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_fadd_rne.sv
// Directed bench for fadd_rne: arithmetic vectors, rounding, range and handshake.
module tb_fadd_rne;
    logic        clk = 1'b0;
    logic        rst, en, sub;
    logic [31:0] adata, bdata, result;
    logic        ovf, unf, nx, done, busy;
    int          checks = 0;
    int          failures = 0;

    fadd_rne dut (
        .clk(clk), .rst(rst), .en(en), .sub(sub),
        .adata(adata), .bdata(bdata), .result(result),
        .ovf(ovf), .unf(unf), .nx(nx), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts at #1 after an edge in an IDLE cycle; ends in the done cycle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_res, input logic [2:0] exp_flags,
                         input bit poke);
        adata = a; bdata = b; sub = s; en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
            if (poke && k == 2) begin
                en = 1'b1; adata = 32'h12345678; bdata = 32'h00abcdef; sub = ~s;
            end else if (poke && k == 3) begin
                en = 1'b0;
            end
            tick();
        end
        check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flags"}, {29'd0, ovf, unf, nx}, {29'd0, exp_flags});
        $display("op %s: a=%h b=%h sub=%0d -> result=%h ovf=%0d unf=%0d nx=%0d",
                 tag, a, b, s, result, ovf, unf, nx);
    endtask

    initial begin
        int seen;
        rst = 1'b1; en = 1'b0; sub = 1'b0; adata = '0; bdata = '0;
        repeat (3) tick();
        check("reset_out", {result[31:0]}, 32'd0);
        check("reset_ctl", {27'd0, ovf, unf, nx, done, busy}, 32'd0);
        rst = 1'b0;
        tick();

        do_op("add_1_2",      32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 0);
        do_op("sub_equal",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 0);
        do_op("cancel",       32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 0);
        do_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 0);
        do_op("tie_odd",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 0);
        do_op("above_half",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001, 0);
        do_op("below_half",   32'h3F800000, 32'h33000001, 1'b0, 32'h3F800000, 3'b001, 0);
        do_op("far_sticky",   32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001, 0);
        do_op("flush_sub",    32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b000, 0);
        do_op("rnd_carry",    32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001, 0);
        do_op("carry_norm",   32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000, 0);
        do_op("neg_result",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 0);
        do_op("neg_neg",      32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 3'b000, 0);
        do_op("sub_neg_b",    32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3'b000, 0);
        do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101, 0);
        do_op("underflow",    32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b011, 0);
`ifdef FADD_SPECIAL_EN
        do_op("nan_in",       32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 0);
        do_op("inf_m_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b000, 0);
        do_op("ninf_p_fin",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 0);
`endif
        // Back-to-back ops above start in each done cycle; now en while busy.
        do_op("poke_busy",    32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) seen++;
        end
        check("single_done", seen, 0);

        // Abort with rst at c+2 after a nonzero result is held.
        adata = 32'h3F800000; bdata = 32'h40000000; sub = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", result, 32'd0);
        check("abort_ctl", {27'd0, ovf, unf, nx, done, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) seen++;
            tick();
        end
        check("abort_quiet", seen, 0);

        // rst and en together: nothing accepted.
        rst = 1'b1; en = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        check("rst_en_busy", {31'd0, busy}, 32'd0);
        do_op("after_rst",    32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
